// File: rtl/apu_pkg.sv
// Shared definitions for the APU frame sequencer: register addresses,
// default step counts, frame-mode encoding and the step-event bundle.
package apu_pkg;

  // CPU-visible register addresses owned by the frame counter
  localparam logic [15:0] ADDR_STATUS = 16'h4015;
  localparam logic [15:0] ADDR_FRAME  = 16'h4017;

  // Default CPU-cycle counts at which the sequencer steps fire
  localparam int unsigned STEP1_DEF = 7457;
  localparam int unsigned STEP2_DEF = 14913;
  localparam int unsigned STEP3_DEF = 22371;
  localparam int unsigned STEP4_DEF = 29829;
  localparam int unsigned STEP5_DEF = 37281;
  localparam int unsigned CW_DEF    = 16;

  // $4017 bit 7 selects the sequence length
  typedef enum logic {
    FRAME_MODE_4STEP = 1'b0,
    FRAME_MODE_5STEP = 1'b1
  } frame_mode_e;

  // Events decoded from the current count
  typedef struct packed {
    logic quarter;
    logic half;
    logic irq_set;
    logic last;
  } step_evt_t;

  // A $4017 write resets the counter 3 or 4 CPU cycles later depending on
  // whether it lands on an even or odd cycle
  function automatic logic [2:0] delay_reload(input logic parity);
    if (parity) begin
      return 3'd4;
    end else begin
      return 3'd3;
    end
  endfunction

endpackage

// File: rtl/apu_frame_counter_if.sv
// CPU bus as seen by the frame counter: the CPU core is the master,
// the frame counter answers as a slave and drives irq.
interface apu_frame_counter_if;
  logic        ce;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        mr;
  logic        mw;
  logic [7:0]  rdata;
  logic        rhit;
  logic        irq;

  modport master (
    output ce, addr, wdata, mr, mw,
    input  rdata, rhit, irq
  );

  modport slave (
    input  ce, addr, wdata, mr, mw,
    output rdata, rhit, irq
  );
endinterface

// File: rtl/apu_frame_counter_step_decode.sv
// Pure decode of the pre-increment cycle count into the sequencer events.
// The IRQ-set term is only the 4-step timing; inhibit is applied by the caller.
module frame_step_decode
  import apu_pkg::*;
#(
  parameter int unsigned STEP1 = STEP1_DEF,
  parameter int unsigned STEP2 = STEP2_DEF,
  parameter int unsigned STEP3 = STEP3_DEF,
  parameter int unsigned STEP4 = STEP4_DEF,
  parameter int unsigned STEP5 = STEP5_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic [CW-1:0] cnt_s,
  input  frame_mode_e   mode_s,
  input  logic          after_wrap_s,
  output step_evt_t     evt_s
);

  logic [CW-1:0] last_cnt_s;
  logic          is_last_s;
  logic          is_step2_s;

  // Step decode: quarter at steps 1-3 and the final step, half at step 2
  // and the final step, IRQ around the end of a 4-step frame
  always_comb begin
    evt_s = '0;
    if (mode_s == FRAME_MODE_5STEP) begin
      last_cnt_s = CW'(STEP5);
    end else begin
      last_cnt_s = CW'(STEP4);
    end
    is_last_s     = (cnt_s == last_cnt_s);
    is_step2_s    = (cnt_s == CW'(STEP2));
    evt_s.last    = is_last_s;
    evt_s.quarter = (cnt_s == CW'(STEP1)) | is_step2_s |
                    (cnt_s == CW'(STEP3)) | is_last_s;
    evt_s.half    = is_step2_s | is_last_s;
    if (mode_s == FRAME_MODE_4STEP) begin
      evt_s.irq_set = (cnt_s == CW'(STEP4 - 1)) | (cnt_s == CW'(STEP4)) |
                      ((cnt_s == '0) & after_wrap_s);
    end else begin
      evt_s.irq_set = 1'b0;
    end
  end

endmodule

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: $4017 mode/inhibit register, frame IRQ flag exposed
// in $4015 bit 6, and quarter/half-frame clocks for envelopes, sweeps and
// length counters. Everything advances on the CPU cycle enable only.
module apu_frame_counter
  import apu_pkg::*;
#(
  parameter int unsigned STEP1 = STEP1_DEF,
  parameter int unsigned STEP2 = STEP2_DEF,
  parameter int unsigned STEP3 = STEP3_DEF,
  parameter int unsigned STEP4 = STEP4_DEF,
  parameter int unsigned STEP5 = STEP5_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  apu_frame_counter_if.slave  bus,
  output logic                quarter_frame,
  output logic                half_frame
);

  // Architectural state
  logic [CW-1:0] cnt_r;
  frame_mode_e   mode_r;
  logic          inhibit_r;
  logic          flag_r;
  logic          parity_r;
  logic          pending_r;
  logic [2:0]    dly_r;
  logic          wrapped_r;
  logic          quarter_r;
  logic          half_r;

  // Next-state values
  logic [CW-1:0] cnt_nx;
  frame_mode_e   mode_nx;
  logic          inhibit_nx;
  logic          flag_nx;
  logic          parity_nx;
  logic          pending_nx;
  logic [2:0]    dly_nx;
  logic          wrapped_nx;
  logic          quarter_nx;
  logic          half_nx;

  // Decoded bus accesses and events
  step_evt_t     evt_s;
  logic          frame_wr_s;
  logic          status_rd_s;
  logic          fire_s;
  logic          irq_set_s;
  logic          rhit_s;
  logic [7:0]    rdata_s;
  logic          unused_wdata_s;

  frame_step_decode #(
    .STEP1 (STEP1),
    .STEP2 (STEP2),
    .STEP3 (STEP3),
    .STEP4 (STEP4),
    .STEP5 (STEP5),
    .CW    (CW)
  ) u_decode (
    .cnt_s        (cnt_r),
    .mode_s       (mode_r),
    .after_wrap_s (wrapped_r),
    .evt_s        (evt_s)
  );

  // Only the two top data bits mean anything to $4017
  assign unused_wdata_s = ^bus.wdata[5:0];

  // Qualify bus strobes and the delayed counter reset for this CPU cycle.
  // A fresh $4017 write restarts the delay, so it overrides an expiring one.
  always_comb begin
    frame_wr_s  = bus.ce & bus.mw & (bus.addr == ADDR_FRAME);
    status_rd_s = bus.ce & bus.mr & (bus.addr == ADDR_STATUS);
    fire_s      = pending_r & (dly_r == 3'd1) & ~frame_wr_s;
    irq_set_s   = evt_s.irq_set & ~inhibit_r & ~fire_s;
  end

  // Next-state logic for the counter, delay, mode register and IRQ flag
  always_comb begin
    cnt_nx     = cnt_r;
    mode_nx    = mode_r;
    inhibit_nx = inhibit_r;
    flag_nx    = flag_r;
    parity_nx  = parity_r;
    pending_nx = pending_r;
    dly_nx     = dly_r;
    wrapped_nx = wrapped_r;
    quarter_nx = 1'b0;
    half_nx    = 1'b0;
    if (bus.ce) begin
      parity_nx = ~parity_r;

      // Count, or take the delayed reset which replaces the normal step
      if (fire_s) begin
        cnt_nx     = '0;
        quarter_nx = (mode_r == FRAME_MODE_5STEP);
        half_nx    = (mode_r == FRAME_MODE_5STEP);
        wrapped_nx = 1'b0;
      end else begin
        if (evt_s.last) begin
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt_r + CW'(1);
        end
        quarter_nx = evt_s.quarter;
        half_nx    = evt_s.half;
        wrapped_nx = evt_s.last;
      end

      // $4017 write loads mode/inhibit and (re)arms the reset delay
      if (frame_wr_s) begin
        mode_nx    = frame_mode_e'(bus.wdata[7]);
        inhibit_nx = bus.wdata[6];
        pending_nx = 1'b1;
        dly_nx     = delay_reload(parity_r);
      end else if (fire_s) begin
        pending_nx = 1'b0;
        dly_nx     = 3'd0;
      end else if (pending_r) begin
        dly_nx     = dly_r - 3'd1;
      end else begin
        dly_nx     = dly_r;
      end

      // Flag priority: inhibit clear, then IRQ set, then status read clear
      if (frame_wr_s & bus.wdata[6]) begin
        flag_nx = 1'b0;
      end else if (irq_set_s) begin
        flag_nx = 1'b1;
      end else if (status_rd_s) begin
        flag_nx = 1'b0;
      end else begin
        flag_nx = flag_r;
      end
    end else begin
      parity_nx = parity_r;
    end
  end

  // State register with synchronous active-low reset; a reset also drops
  // any counter reset still waiting in the delay
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r     <= '0;
      mode_r    <= FRAME_MODE_4STEP;
      inhibit_r <= 1'b0;
      flag_r    <= 1'b0;
      parity_r  <= 1'b0;
      pending_r <= 1'b0;
      dly_r     <= 3'd0;
      wrapped_r <= 1'b0;
      quarter_r <= 1'b0;
      half_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_nx;
      mode_r    <= mode_nx;
      inhibit_r <= inhibit_nx;
      flag_r    <= flag_nx;
      parity_r  <= parity_nx;
      pending_r <= pending_nx;
      dly_r     <= dly_nx;
      wrapped_r <= wrapped_nx;
      quarter_r <= quarter_nx;
      half_r    <= half_nx;
    end
  end

  // Status read path: only the frame IRQ flag lives in bit 6
  always_comb begin
    rhit_s = bus.mr & (bus.addr == ADDR_STATUS);
    if (rhit_s) begin
      rdata_s = {1'b0, flag_r, 6'b000000};
    end else begin
      rdata_s = 8'h00;
    end
  end

  assign bus.rhit      = rhit_s;
  assign bus.rdata     = rdata_s;
  assign bus.irq       = flag_r;
  assign quarter_frame = quarter_r;
  assign half_frame    = half_r;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Bench for apu_frame_counter: instance 0 uses the real step counts and runs
// directed frame sequences; instance 1 uses short frames and random bus
// traffic. Both are checked every cycle against a frame-level model.
module tb_apu_frame_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done0 = 1'b0;
  bit done1 = 1'b0;

  // Stimulus per instance
  logic        rstn[2];
  logic        tce[2];
  logic [15:0] taddr[2];
  logic [7:0]  twdata[2];
  logic        tmr[2];
  logic        tmw[2];

  // Observed outputs per instance
  logic        oirq[2];
  logic        orhit[2];
  logic [7:0]  ordata[2];
  logic        oqf[2];
  logic        ohf[2];
  logic        qf0, hf0, qf1, hf1;

  apu_frame_counter_if bus0 ();
  apu_frame_counter_if bus1 ();

  assign bus0.ce = tce[0];  assign bus0.addr = taddr[0]; assign bus0.wdata = twdata[0];
  assign bus0.mr = tmr[0];  assign bus0.mw = tmw[0];
  assign bus1.ce = tce[1];  assign bus1.addr = taddr[1]; assign bus1.wdata = twdata[1];
  assign bus1.mr = tmr[1];  assign bus1.mw = tmw[1];
  assign oirq[0] = bus0.irq;   assign orhit[0] = bus0.rhit; assign ordata[0] = bus0.rdata;
  assign oirq[1] = bus1.irq;   assign orhit[1] = bus1.rhit; assign ordata[1] = bus1.rdata;
  assign oqf[0] = qf0; assign ohf[0] = hf0; assign oqf[1] = qf1; assign ohf[1] = hf1;

  apu_frame_counter dut0 (
    .clk           (clk),
    .reset_n       (rstn[0]),
    .bus           (bus0),
    .quarter_frame (qf0),
    .half_frame    (hf0)
  );

  apu_frame_counter #(
    .STEP1 (11), .STEP2 (23), .STEP3 (37), .STEP4 (50), .STEP5 (63), .CW (16)
  ) dut1 (
    .clk           (clk),
    .reset_n       (rstn[1]),
    .bus           (bus1),
    .quarter_frame (qf1),
    .half_frame    (hf1)
  );

  // Step tables per instance
  int P1[2] = '{7457, 11};
  int P2[2] = '{14913, 23};
  int P3[2] = '{22371, 37};
  int P4[2] = '{29829, 50};
  int P5[2] = '{37281, 63};

  // Model state: counter resets are scheduled by absolute CPU-cycle index
  int mCnt[2], mCeIdx[2], mFireAt[2];
  bit mMode[2], mInh[2], mFlag[2], mPar[2], mWrapped[2], mQf[2], mHf[2], mValid[2];

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s actual=%0d expected=%0d at %0t", k, nm, act, exp, $time);
    end
  endtask

  task automatic modelStep(input int k);
    int  last;
    bit  wr, rd, fire, setIrq, q, h;
    if (!rstn[k]) begin
      mCnt[k] = 0; mMode[k] = 0; mInh[k] = 0; mFlag[k] = 0; mPar[k] = 0;
      mFireAt[k] = -1; mCeIdx[k] = 0; mWrapped[k] = 0; mQf[k] = 0; mHf[k] = 0;
      mValid[k] = 1;
    end else if (!tce[k]) begin
      mQf[k] = 0; mHf[k] = 0;
    end else begin
      mCeIdx[k]++;
      last = mMode[k] ? P5[k] : P4[k];
      wr = tmw[k] && (taddr[k] == 16'h4017);
      rd = tmr[k] && (taddr[k] == 16'h4015);
      fire = !wr && (mFireAt[k] == mCeIdx[k]);
      if (fire) begin
        q = mMode[k]; h = mMode[k]; setIrq = 0;
      end else begin
        q = (mCnt[k] == P1[k]) || (mCnt[k] == P2[k]) || (mCnt[k] == P3[k]) || (mCnt[k] == last);
        h = (mCnt[k] == P2[k]) || (mCnt[k] == last);
        setIrq = !mMode[k] && !mInh[k] &&
                 ((mCnt[k] == P4[k] - 1) || (mCnt[k] == P4[k]) || (mCnt[k] == 0 && mWrapped[k]));
      end
      mQf[k] = q; mHf[k] = h;
      mWrapped[k] = !fire && (mCnt[k] == last);
      mCnt[k] = (fire || mCnt[k] == last) ? 0 : (mCnt[k] + 1) % 65536;
      if (wr && twdata[k][6]) mFlag[k] = 0;
      else if (setIrq)        mFlag[k] = 1;
      else if (rd)            mFlag[k] = 0;
      if (wr) begin
        mMode[k] = twdata[k][7];
        mInh[k]  = twdata[k][6];
        mFireAt[k] = mCeIdx[k] + (mPar[k] ? 4 : 3);
      end else if (fire) begin
        mFireAt[k] = -1;
      end
      mPar[k] = !mPar[k];
    end
  endtask

  // Advance the model on the same edge the DUTs sample their inputs
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) modelStep(k);
  end

  // Compare all outputs mid-cycle
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mValid[k]) begin
        bit hit;
        hit = tmr[k] && (taddr[k] == 16'h4015);
        chk(k, "rhit", orhit[k], hit);
        chk(k, "rdata", ordata[k], (hit && mFlag[k]) ? 8'h40 : 8'h00);
        chk(k, "irq", oirq[k], mFlag[k]);
        chk(k, "quarter_frame", oqf[k], mQf[k]);
        chk(k, "half_frame", ohf[k], mHf[k]);
      end
    end
  end

  task automatic setBus(input int k, input bit c, input logic [15:0] a, input logic [7:0] d,
                        input bit r, input bit w);
    tce[k] = c; taddr[k] = a; twdata[k] = d; tmr[k] = r; tmw[k] = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    setBus(k, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

  // Instance 0: full-length frames with the real step counts
  initial begin : stim0
    int firstQ, firstH, firstIrq, nQ, nH, firstQH, lastQH, irqSeen;
    rstn[0] = 1'b0;
    setBus(0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    chk(0, "reset_irq", oirq[0], 0);
    chk(0, "reset_qf", oqf[0], 0);
    chk(0, "reset_hf", ohf[0], 0);
    rstn[0] = 1'b1;

    // 4-step frame; a status read on the count-29828 cycle must lose to the set
    firstQ = 0; firstH = 0; firstIrq = 0; nQ = 0; nH = 0;
    for (int i = 1; i <= 29831; i++) begin
      if (i == 29829) setBus(0, 1'b1, 16'h4015, 8'h00, 1'b1, 1'b0);
      else            setBus(0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
      tick();
      if (oqf[0]) begin nQ++; if (firstQ == 0) firstQ = i; end
      if (ohf[0]) begin nH++; if (firstH == 0) firstH = i; end
      if (oirq[0] && firstIrq == 0) firstIrq = i;
      if (i == 29829) chk(0, "irq_set_beats_read", oirq[0], 1);
    end
    chk(0, "first_quarter_edge", firstQ, 7458);
    chk(0, "first_half_edge", firstH, 14914);
    chk(0, "first_irq_edge", firstIrq, 29829);
    chk(0, "quarter_count_4step", nQ, 4);
    chk(0, "half_count_4step", nH, 2);

    // Foreign addresses: no hit, no data, no effect on the flag
    setBus(0, 1'b1, 16'h4016, 8'hC0, 1'b0, 1'b1);
    #2;
    chk(0, "wr4016_rhit", orhit[0], 0);
    tick();
    setBus(0, 1'b1, 16'h4014, 8'h00, 1'b1, 1'b0);
    #2;
    chk(0, "rd4014_rhit", orhit[0], 0);
    chk(0, "rd4014_rdata", ordata[0], 8'h00);
    tick();
    chk(0, "irq_after_foreign", oirq[0], 1);

    // Status reads: first returns the flag and clears it, second sees 0
    setBus(0, 1'b1, 16'h4015, 8'h00, 1'b1, 1'b0);
    #2;
    chk(0, "read1_rdata", ordata[0], 8'h40);
    chk(0, "read1_rhit", orhit[0], 1);
    tick();
    chk(0, "irq_after_read", oirq[0], 0);
    setBus(0, 1'b1, 16'h4015, 8'h00, 1'b1, 1'b0);
    #2;
    chk(0, "read2_rdata", ordata[0], 8'h00);
    tick();

    // 5-step mode written on an even cycle, then one full 5-step frame
    if (mPar[0]) idle(0);
    setBus(0, 1'b1, 16'h4017, 8'h80, 1'b0, 1'b1);
    tick();
    firstQH = 0; lastQH = 0; nQ = 0; irqSeen = 0;
    for (int j = 1; j <= 37285; j++) begin
      idle(0);
      if (oqf[0] && ohf[0]) begin if (firstQH == 0) firstQH = j; lastQH = j; end
      if (oqf[0]) nQ++;
      if (oirq[0]) irqSeen = 1;
    end
    chk(0, "even_write_reset_delay", firstQH, 3);
    chk(0, "last_5step_pulse", lastQH, 37285);
    chk(0, "quarter_count_5step", nQ, 5);
    chk(0, "irq_in_5step", irqSeen, 0);

    // Odd-cycle write: counter reset lands one CPU cycle later
    if (!mPar[0]) idle(0);
    setBus(0, 1'b1, 16'h4017, 8'h80, 1'b0, 1'b1);
    tick();
    firstQH = 0;
    for (int j = 1; j <= 8; j++) begin
      idle(0);
      if (oqf[0] && ohf[0] && firstQH == 0) firstQH = j;
    end
    chk(0, "odd_write_reset_delay", firstQH, 4);

    // Reset while a counter reset is pending cancels it
    setBus(0, 1'b1, 16'h4017, 8'h80, 1'b0, 1'b1);
    tick();
    idle(0);
    rstn[0] = 1'b0;
    idle(0);
    rstn[0] = 1'b1;
    nQ = 0;
    for (int j = 1; j <= 12; j++) begin
      idle(0);
      if (oqf[0]) nQ++;
    end
    chk(0, "no_reset_after_cancel", nQ, 0);
    done0 = 1'b1;
  end

  // Instance 1: short frames, inhibit behaviour, then random traffic
  initial begin : stim1
    int n, irqSeen, sel;
    logic [15:0] a;
    rstn[1] = 1'b0;
    setBus(1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    rstn[1] = 1'b1;

    n = 0;
    while (!oirq[1] && n < 200) begin
      idle(1);
      n++;
    end
    chk(1, "short_frame_irq_edge", n, 50);

    setBus(1, 1'b1, 16'h4017, 8'h40, 1'b0, 1'b1);
    tick();
    chk(1, "inhibit_clears_irq", oirq[1], 0);
    irqSeen = 0;
    for (int j = 0; j < 140; j++) begin
      idle(1);
      if (oirq[1]) irqSeen = 1;
    end
    chk(1, "inhibited_frames_irq", irqSeen, 0);

    for (int j = 0; j < 20000; j++) begin
      sel = $urandom % 8;
      case (sel)
        0, 1:    a = 16'h4015;
        2:       a = 16'h4017;
        3:       a = 16'h4016;
        4:       a = 16'h4014;
        default: a = 16'($urandom);
      endcase
      setBus(1, ($urandom % 4) != 0, a, 8'($urandom), ($urandom % 6) == 0, ($urandom % 40) == 0);
      rstn[1] = ($urandom % 2500) != 0;
      tick();
    end
    rstn[1] = 1'b1;
    idle(1);
    done1 = 1'b1;
  end

  // Summary with a cycle-budget watchdog
  initial begin : summary
    fork
      wait (done0 && done1);
      repeat (90000) @(posedge clk);
    join_any
    checks++;
    if (!(done0 && done1)) begin
      errors++;
      $display("FAIL watchdog actual=%0d expected=%0d", done0 && done1, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
